// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue: FSM states, queue entry layout, fetch stride.
package ifq_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [0:0] {
    IFQ_FETCH,
    IFQ_HOLD
  } ifq_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  function automatic logic [31:0] ifq_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_ring_buffer.sv
// Power-of-two ring of fetched {pc, instr} entries with push, pop and a clear that wins over both.
module ifq_ring_buffer
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  ifq_entry_t                   push_entry_i,
  input  logic                         pop_i,
  output ifq_entry_t                   head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  ifq_entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]       head_q, head_d;
  logic [PtrW-1:0]       tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  do_push, do_pop;

  assign do_push = push_i & ~clear_i;
  assign do_pop  = pop_i & ~clear_i;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PtrW'(1);
      if (do_pop)  head_d = head_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) mem_q[tail_q] <= push_entry_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Sequential instruction prefetcher with epoch-tagged single outstanding fetch and redirect flush.
// Optional discard counter on flush_count is built when IFQ_FLUSH_COUNTER_EN is defined.
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH            = 4,
  parameter logic [31:0] PC_START_ADDRESS = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  output logic [31:0] inst_mem_addr,
  output logic        inst_mem_req,
  input  logic [31:0] inst_mem_rd_data,
  input  logic        mem_port_busy,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus_4,
  output logic [31:0] flush_count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  ifq_state_t      state_q;
  logic [31:0]     fetch_pc_q;
  logic [31:0]     inflight_pc_q;
  logic            inflight_q;
  logic            inflight_tag_q;
  logic            epoch_q;
  ifq_entry_t      out_hold_q;

  ifq_entry_t      head_entry;
  ifq_entry_t      push_entry;
  logic [CntW-1:0] count;
  logic [CntW:0]   occupancy;
  logic            space;
  logic            resp_live;
  logic            issue;
  logic            push, pop, clear;

  // An outstanding fetch reserves a slot so its response can never overflow the ring.
  assign occupancy = {1'b0, count} + {{CntW{1'b0}}, inflight_q};
  assign space     = occupancy < (CntW + 1)'(DEPTH);
  assign resp_live = inflight_q & (inflight_tag_q == epoch_q);

  assign issue = rst & ena & (state_q == IFQ_FETCH) & ~mem_port_busy & ~redirect & space;
  assign push  = ena & ~redirect & resp_live;
  assign pop   = ena & ~redirect & out_valid & out_ready;
  assign clear = ena & redirect;

  assign push_entry = '{pc: inflight_pc_q, instr: inst_mem_rd_data};

  ifq_ring_buffer #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk_i        (clk),
    .rst_ni       (rst),
    .clear_i      (clear),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head_entry),
    .count_o      (count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IFQ_FETCH;
      fetch_pc_q     <= ifq_align(PC_START_ADDRESS);
      inflight_pc_q  <= '0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= 1'b0;
      epoch_q        <= 1'b0;
    end else if (ena) begin
      if (redirect) begin
        state_q    <= IFQ_FETCH;
        fetch_pc_q <= ifq_align(redirect_pc);
        epoch_q    <= ~epoch_q;
        inflight_q <= 1'b0;
      end else begin
        unique case (state_q)
          IFQ_FETCH: if (mem_port_busy || !space) state_q <= IFQ_HOLD;
          IFQ_HOLD:  if (!mem_port_busy && space) state_q <= IFQ_FETCH;
          default:   state_q <= IFQ_FETCH;
        endcase
        inflight_q <= issue;
        if (issue) begin
          fetch_pc_q     <= fetch_pc_q + INSTR_BYTES;
          inflight_pc_q  <= fetch_pc_q;
          inflight_tag_q <= epoch_q;
        end
      end
    end
  end

  // Tracks the entry last shown so outputs hold steady while the ring is empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_hold_q <= '0;
    end else if (ena && out_valid) begin
      out_hold_q <= head_entry;
    end
  end

  assign inst_mem_req  = issue;
  assign inst_mem_addr = issue ? fetch_pc_q : '0;

  assign out_valid     = (count != '0);
  assign out_instr     = out_valid ? head_entry.instr : out_hold_q.instr;
  assign out_pc        = out_valid ? head_entry.pc : out_hold_q.pc;
  assign out_pc_plus_4 = out_pc + INSTR_BYTES;

`ifdef IFQ_FLUSH_COUNTER_EN
  logic [31:0] flush_count_q;
  logic [32:0] flush_sum;

  assign flush_sum = {1'b0, flush_count_q} + 33'(count) + 33'(resp_live);

  always_ff @(posedge clk) begin
    if (!rst) begin
      flush_count_q <= '0;
    end else if (ena && redirect) begin
      flush_count_q <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end

  assign flush_count = flush_count_q;
`else
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (DEPTH=4, start address 0x100) with a 1-cycle memory model.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [31:0] inst_mem_addr;
  logic        inst_mem_req;
  logic [31:0] inst_mem_rd_data;
  logic        mem_port_busy;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [31:0] flush_count;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_req;
  logic [31:0] exp_out;

  inst_fetch_queue #(
    .DEPTH            (4),
    .PC_START_ADDRESS (32'h100)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ena              (ena),
    .inst_mem_addr    (inst_mem_addr),
    .inst_mem_req     (inst_mem_req),
    .inst_mem_rd_data (inst_mem_rd_data),
    .mem_port_busy    (mem_port_busy),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .out_pc_plus_4    (out_pc_plus_4),
    .flush_count      (flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  always @(posedge clk) inst_mem_rd_data <= inst_mem_req ? w(inst_mem_addr) : 32'hBAD0_BAD0;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Consume continuously; every issued address and every delivered entry must be contiguous.
  task automatic stream(input int n, input int busy_from, input int busy_to);
    for (int i = 0; i < n; i++) begin
      nxt();
      out_ready     = 1'b1;
      mem_port_busy = (i >= busy_from) && (i < busy_to);
      #1;
      if (mem_port_busy) begin
        chk("busy_no_req", {31'b0, inst_mem_req}, 32'd0);
      end else if (inst_mem_req) begin
        chk("stream_req_addr", inst_mem_addr, exp_req);
        exp_req += 32'd4;
      end
      if (out_valid) begin
        chk("stream_out_pc", out_pc, exp_out);
        chk("stream_out_instr", out_instr, w(exp_out));
        exp_out += 32'd4;
      end
    end
    mem_port_busy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ena = 1'b1; mem_port_busy = 1'b0; redirect = 1'b0;
    redirect_pc = '0; out_ready = 1'b1;

    // Reset state
    nxt();
    nxt();
    #1;
    chk("rst_req", {31'b0, inst_mem_req}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_flush", flush_count, 32'd0);

    // Start-up stream from 0x100
    nxt(); rst = 1'b1; #1;                                       // c0
    chk("c0_req", {31'b0, inst_mem_req}, 32'd1);
    chk("c0_addr", inst_mem_addr, 32'h100);
    nxt(); #1;                                                   // c1
    chk("c1_valid", {31'b0, out_valid}, 32'd0);
    chk("c1_addr", inst_mem_addr, 32'h104);
    nxt(); #1;                                                   // c2
    chk("c2_valid", {31'b0, out_valid}, 32'd1);
    chk("c2_pc", out_pc, 32'h100);
    chk("c2_pc4", out_pc_plus_4, 32'h104);
    chk("c2_instr", out_instr, w(32'h100));
    chk("c2_addr", inst_mem_addr, 32'h108);
    nxt(); #1;                                                   // c3
    chk("c3_pc", out_pc, 32'h104);

    // Redirect to 0x0 then fill with decode stalled
    nxt(); out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0; #1;   // c4
    chk("c4_req", {31'b0, inst_mem_req}, 32'd0);
    nxt(); redirect = 1'b0; #1;                                  // c5
    chk("c5_valid", {31'b0, out_valid}, 32'd0);
    chk("c5_hold_pc", out_pc, 32'h108);
    chk("c5_addr", inst_mem_addr, 32'h0);
    nxt(); nxt(); nxt(); #1;                                     // c8
    chk("c8_addr", inst_mem_addr, 32'hC);
    nxt(); #1;                                                   // c9
    chk("c9_req", {31'b0, inst_mem_req}, 32'd0);
    nxt(); out_ready = 1'b1; #1;                                 // c10
    chk("c10_valid", {31'b0, out_valid}, 32'd1);
    chk("c10_pc", out_pc, 32'h0);
    chk("c10_req", {31'b0, inst_mem_req}, 32'd0);
    nxt(); out_ready = 1'b0; #1;                                 // c11
    chk("c11_pc", out_pc, 32'h4);
    chk("c11_req", {31'b0, inst_mem_req}, 32'd0);
    nxt(); #1;                                                   // c12
    chk("c12_req", {31'b0, inst_mem_req}, 32'd1);
    chk("c12_addr", inst_mem_addr, 32'h10);
    nxt(); #1;                                                   // c13
    chk("c13_req", {31'b0, inst_mem_req}, 32'd0);

    // Redirect with full queue and out_ready high; misaligned target
    nxt(); redirect = 1'b1; redirect_pc = 32'h43; out_ready = 1'b1; #1;  // c14
    chk("c14_valid", {31'b0, out_valid}, 32'd1);
    chk("c14_pc", out_pc, 32'h4);
    nxt(); redirect = 1'b0; out_ready = 1'b0; #1;                // c15
    chk("c15_valid", {31'b0, out_valid}, 32'd0);
    chk("c15_hold_pc", out_pc, 32'h4);
    chk("c15_addr", inst_mem_addr, 32'h40);
`ifdef IFQ_FLUSH_COUNTER_EN
    chk("c15_flush", flush_count, 32'd6);
`else
    chk("c15_flush", flush_count, 32'd0);
`endif
    nxt(); nxt(); nxt(); nxt(); #1;                              // c19
    chk("c19_req", {31'b0, inst_mem_req}, 32'd0);
    chk("c19_pc", out_pc, 32'h40);

    // Drain across the pointer wrap
    exp_req = 32'h50;
    exp_out = 32'h40;
    stream(10, 10, 10);
    chk("wrap_out_progress", exp_out, 32'h68);

    // Three busy cycles mid-stream
    stream(12, 3, 6);
    chk("busy_out_progress", exp_out, 32'h88);
    chk("busy_req_progress", exp_req, 32'h90);

    // Reset the cycle after a request
    nxt(); out_ready = 1'b0; #1;                                 // x
    chk("pre_rst_req", {31'b0, inst_mem_req}, 32'd1);
    nxt(); rst = 1'b0; #1;                                       // x+1
    chk("in_rst_req", {31'b0, inst_mem_req}, 32'd0);
    nxt(); rst = 1'b1; #1;                                       // x+2
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("post_rst_addr", inst_mem_addr, 32'h100);
    chk("post_rst_flush", flush_count, 32'd0);
    nxt(); #1;                                                   // x+3
    chk("x3_valid", {31'b0, out_valid}, 32'd0);
    chk("x3_addr", inst_mem_addr, 32'h104);
    nxt(); #1;                                                   // x+4
    chk("x4_pc", out_pc, 32'h100);
    chk("x4_instr", out_instr, w(32'h100));

    // Redirect with two queued and one in flight
    nxt(); redirect = 1'b1; redirect_pc = 32'h2000; #1;          // x+5
    chk("x5_req", {31'b0, inst_mem_req}, 32'd0);
    chk("x5_pc", out_pc, 32'h100);
    nxt(); redirect = 1'b0; #1;                                  // x+6
    chk("x6_valid", {31'b0, out_valid}, 32'd0);
    chk("x6_addr", inst_mem_addr, 32'h2000);
`ifdef IFQ_FLUSH_COUNTER_EN
    chk("x6_flush", flush_count, 32'd3);
`else
    chk("x6_flush", flush_count, 32'd0);
`endif
    nxt(); #1;                                                   // x+7
    chk("x7_valid", {31'b0, out_valid}, 32'd0);
    chk("x7_addr", inst_mem_addr, 32'h2004);
    nxt(); #1;                                                   // x+8
    chk("x8_pc", out_pc, 32'h2000);
    chk("x8_instr", out_instr, w(32'h2000));
    chk("x8_pc4", out_pc_plus_4, 32'h2004);

    // Back-to-back redirects: last target wins, low bits dropped
    nxt(); redirect = 1'b1; redirect_pc = 32'h3000; #1;          // x+9
    nxt(); redirect_pc = 32'h3006; #1;                           // x+10
    chk("x10_req", {31'b0, inst_mem_req}, 32'd0);
    nxt(); redirect = 1'b0; #1;                                  // x+11
    chk("x11_req", {31'b0, inst_mem_req}, 32'd1);
    chk("x11_addr", inst_mem_addr, 32'h3004);
    nxt(); #1;                                                   // x+12
    chk("x12_addr", inst_mem_addr, 32'h3008);

    // Global enable low freezes everything
    nxt(); ena = 1'b0; out_ready = 1'b1; #1;                     // x+13
    chk("x13_valid", {31'b0, out_valid}, 32'd1);
    chk("x13_pc", out_pc, 32'h3004);
    chk("x13_req", {31'b0, inst_mem_req}, 32'd0);
    nxt(); #1;                                                   // x+14
    chk("x14_valid", {31'b0, out_valid}, 32'd1);
    chk("x14_pc", out_pc, 32'h3004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction prefetch stage between the synchronous-read instruction memory and the pipelined core's decode input.
- Runs ahead of decode: issues sequential fetches, buffers {pc, instr} pairs in a small ring, and hands them to the core with a valid/ready handshake.
- Discards everything on a redirect (taken branch/jump), including a fetch still in flight.
- Backs off when the memory stage is using the single-ported instruction memory.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- PC_START_ADDRESS, 0, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- ena  in  1  global enable; when 0, no state changes at all
- inst_mem_addr  out  32  fetch address, word aligned
- inst_mem_req  out  1  fetch issued this cycle
- inst_mem_rd_data  in  32  read data, valid exactly 1 cycle after an issued req
- mem_port_busy  in  1  memory stage owns the instruction memory this cycle; no req may issue
- redirect  in  1  flush queue and restart fetch
- redirect_pc  in  32  new fetch address
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head
- out_instr  out  32  head instruction
- out_pc  out  32  head PC
- out_pc_plus_4  out  32  out_pc + 4, mod 2^32
- flush_count  out  32  feature counter (see Optional Feature)

Behaviour:
- Reset (rst==0 at a clk edge):
  - fetch_pc = PC_START_ADDRESS.
  - Queue empty, count=0, in-flight=0, epoch=0, state=FETCH.
  - Outputs: out_valid=0, inst_mem_req=0, out_instr=0, out_pc=0, flush_count=0.
  - Reset overrides redirect, ena and any in-flight response. The response arriving the cycle after reset is dropped.
- Two-state FSM:
  - FETCH: issue inst_mem_req=1 with inst_mem_addr=fetch_pc when all of:
    - ena=1
    - mem_port_busy=0
    - redirect=0
    - count + inflight < DEPTH (space reserved for the outstanding response)
    - On issue: fetch_pc += 4; inflight=1, tagged with the current epoch.
    - Go to HOLD when mem_port_busy=1 or the queue is full with an issue wanted.
  - HOLD: inst_mem_req=0 and inst_mem_addr=0. Return to FETCH when both conditions clear.
  - Redirect from either state goes to FETCH.
- Response: the cycle after an issue, if the tag equals the current epoch, inst_mem_rd_data is enqueued at the tail with its PC. On an epoch mismatch it is dropped.
- Dequeue occurs when out_valid & out_ready & ena.
- Simultaneous enqueue and dequeue: count unchanged. Wrap-around uses modulo-DEPTH pointers.
- Full (count==DEPTH): no enqueue possible; guaranteed by the reservation rule.
- Empty: out_valid=0; out_instr and out_pc hold their last values.
- No bypass: a response becomes visible on out_* no earlier than 1 cycle after it arrives, so issue-to-out_valid latency is 2 cycles.
- redirect=1 (takes priority over enqueue, dequeue and issue in the same cycle):
  - Pointers and count cleared; out_valid=0 next cycle.
  - epoch toggles, so any in-flight response is dropped.
  - fetch_pc = redirect_pc; next-cycle issue at redirect_pc if allowed.
  - An out_ready in the same cycle is ignored: nothing is consumed.
- Back-to-back redirects: only the last redirect_pc is fetched.
- Misaligned redirect_pc: bits [1:0] are forced to 0.

Optional Feature:
- Macro: IFQ_FLUSH_COUNTER_EN.
- Defined: flush_count increments by the number of valid queue entries plus a live in-flight response discarded on each redirect. It saturates at 2^32-1 and clears only on reset.
- Undefined: flush_count is tied to 0 and no counter logic exists.

Decomposition:
- Package ifq_pkg:
  - typedef ifq_state_t {IFQ_FETCH, IFQ_HOLD}
  - struct ifq_entry_t {pc[31:0], instr[31:0]}
  - localparam INSTR_BYTES=4
- Sub-module ifq_ring_buffer:
  - Parameterised DEPTH storage of ifq_entry_t.
  - Holds head/tail pointers and count, with push, pop and clear.
  - The top level owns the FSM, epoch and in-flight logic.

Test Plan:
- Reset with PC_START_ADDRESS=0x100, out_ready=1 → reqs at 0x100, 0x104, 0x108…; the first out_valid appears 2 cycles after the first req, with out_pc=0x100 and out_pc_plus_4=0x104.
- out_ready=0, DEPTH=4 → exactly 4 reqs (0x0..0xC), then inst_mem_req=0. With out_ready=1 for one cycle: one entry is dequeued and one new req at 0x10 issues.
- redirect=1 with redirect_pc=0x2000 while a req at 0x8 is in flight and 2 entries are queued → 0x8 data is dropped and out_valid=0. The next req is at 0x2000 and the next out_pc is 0x2000. With the macro defined, flush_count=3.
- mem_port_busy=1 for 3 cycles mid-stream → no req during those cycles, no PC skipped or duplicated, and the output sequence stays contiguous.
- rst=0 asserted the cycle after a req → that response is not enqueued; out_valid=0 and fetch restarts at PC_START_ADDRESS.
- redirect and out_ready asserted together with the queue full → queue empty next cycle, no entry consumed, pointers wrap correctly on later fills.
